// File: rtl/rx_block_ctrl.sv
// rx_block_ctrl: handshake FSM steering an external 64-in/128-out shift register
// that assembles two half-blocks into one AES block.
module rx_block_ctrl #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 shift_enable,
  input  logic                 flush,
  output logic                 block_valid,
  input  logic                 block_ready,
  output logic [CNT_WIDTH-1:0] block_count,
  output logic                 half_full
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  state_t state, state_nx;
  logic   take;
  always_ff @(posedge clk)
    if (!n_rst) begin
      state       <= EMPTY;
      block_count <= '0;
    end else begin
      state <= state_nx;
      if (take) block_count <= block_count + CNT_WIDTH'(1);
    end
  // consuming a held block frees the register, so a new half may shift in on the same edge
  always_comb begin
    block_valid  = state == FULL;
    half_full    = state == HALF;
    word_ready   = !flush && (!block_valid || block_ready);
    shift_enable = word_valid && word_ready;
    take         = block_valid && block_ready && !flush;
    state_nx     = flush ? EMPTY :
                   take ? (shift_enable ? HALF : EMPTY) :
                   shift_enable ? (half_full ? FULL : HALF) : state;
  end
endmodule
